dwa_sel18: RTL



---
 rtl/dac_pkg.sv | 46 ++++
 rtl/dwa_mask18.sv | 30 +++
 rtl/dwa_sel18.sv | 90 +++++++++
 3 files changed

// File: rtl/dac_pkg.sv
// Shared DAC definitions: element count, code/pointer widths, SV vector type,
// the registered selector payload and small modulo-18 arithmetic helpers.
package dac_pkg;

  localparam int unsigned N_ELEM   = 18;
  localparam int unsigned CODE_W   = 5;
  localparam int unsigned PTR_W    = 5;
  localparam int unsigned MAX_CODE = 18;

  // Element selection vector, also consumed by the transition detector.
  typedef logic [N_ELEM-1:0] sv_t;
  typedef logic [CODE_W-1:0] code_t;
  typedef logic [PTR_W-1:0]  ptr_t;
  // One bit wider than the pointer so ptr + code cannot overflow.
  typedef logic [PTR_W:0]    psum_t;

  // Rotation direction encoding (only used by the bidirectional build).
  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_BWD = 1'b1;

  // Registered selector outputs travelling together.
  typedef struct packed {
    sv_t  sv;
    ptr_t ptr;
    logic ovr;
  } dwa_out_t;

  // Clamp a code to the number of available elements.
  function automatic code_t sat_code(input code_t code);
    if (code > code_t'(MAX_CODE)) begin
      return code_t'(MAX_CODE);
    end
    return code;
  endfunction

  // (a + b) mod 18 for a <= 17, b <= 18: a single conditional subtract.
  function automatic ptr_t wrap18(input ptr_t a, input code_t b);
    psum_t s;
    s = psum_t'(a) + psum_t'(b);
    if (s >= psum_t'(N_ELEM)) begin
      s = s - psum_t'(N_ELEM);
    end
    return ptr_t'(s);
  endfunction

endpackage

// File: rtl/dwa_mask18.sv
// Combinational DWA mask: thermometer of c_i ones rotated left by rot_i
// (mod 18). rot_i is expected in 0..17 and c_i in 0..18.
module dwa_mask18
  import dac_pkg::*;
(
  input  logic [CODE_W-1:0] c_i,
  input  logic [PTR_W-1:0]  rot_i,
  output logic [N_ELEM-1:0] mask_o_c
);

  sv_t                    therm;
  logic [2*N_ELEM-1:0]    dbl;

  // Thermometer code: lowest c_i bits set, all ones once c_i reaches 18.
  always_comb begin
    therm = '0;
    if (c_i >= code_t'(MAX_CODE)) begin
      therm = '1;
    end else begin
      therm = (sv_t'(1) << c_i) - sv_t'(1);
    end
  end

  // Rotate by shifting a doubled copy; the upper half is the wrapped result.
  always_comb begin
    dbl      = {therm, therm} << rot_i;
    mask_o_c = dbl[2*N_ELEM-1 -: N_ELEM];
  end

endmodule

// File: rtl/dwa_sel18.sv
// DWA element selector for the 18-element DAC. Saturates the quantizer code,
// rotates a thermometer mask around the pointer and registers SV/ptr/ovr.
// Optional macro DWA_BIDIR_EN: alternate forward/backward rotation on every
// enabled sample (port list unchanged).
module dwa_sel18
  import dac_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic [CODE_W-1:0] code,
  output logic [N_ELEM-1:0] SV,
  output logic [PTR_W-1:0]  ptr,
  output logic              ovr
);

  dwa_out_t out_q, out_d;
  code_t    c_sat;
  ptr_t     ptr_fwd;
  sv_t      mask_fwd;

  assign c_sat   = sat_code(code);
  assign ptr_fwd = wrap18(out_q.ptr, c_sat);

  dwa_mask18 u_mask_fwd (
    .c_i      (c_sat),
    .rot_i    (out_q.ptr),
    .mask_o_c (mask_fwd)
  );

`ifdef DWA_BIDIR_EN
  logic dir_q, dir_d;
  ptr_t ptr_bwd;
  sv_t  mask_bwd;

  // Going backward by c is going forward by 18 - c; the backward selection
  // is the forward mask anchored at the new pointer.
  assign ptr_bwd = wrap18(out_q.ptr, code_t'(MAX_CODE) - c_sat);

  dwa_mask18 u_mask_bwd (
    .c_i      (c_sat),
    .rot_i    (ptr_bwd),
    .mask_o_c (mask_bwd)
  );
`endif

  // Next-state: hold unless enabled, then select elements and advance pointer.
  always_comb begin
    out_d = out_q;
`ifdef DWA_BIDIR_EN
    dir_d = dir_q;
`endif
    if (clk_en) begin
      out_d.ovr = (code > code_t'(MAX_CODE));
`ifdef DWA_BIDIR_EN
      if (dir_q == DIR_BWD) begin
        out_d.sv  = mask_bwd;
        out_d.ptr = ptr_bwd;
      end else begin
        out_d.sv  = mask_fwd;
        out_d.ptr = ptr_fwd;
      end
      dir_d = ~dir_q;
`else
      out_d.sv  = mask_fwd;
      out_d.ptr = ptr_fwd;
`endif
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
`ifdef DWA_BIDIR_EN
      dir_q <= DIR_FWD;
`endif
    end else begin
      out_q <= out_d;
`ifdef DWA_BIDIR_EN
      dir_q <= dir_d;
`endif
    end
  end

  assign SV  = out_q.sv;
  assign ptr = out_q.ptr;
  assign ovr = out_q.ovr;

endmodule
